// File: rtl/sequential_divider.sv
// rtl/sequential_divider.sv - restoring integer divider, one quotient bit per clock, start/done handshake
// Optional two's-complement mode is enabled by defining DIVIDER_SIGNED_EN.
module sequential_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    // ZDIV is a one-cycle hop so a zero divisor reports done one edge after accept.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ZDIV = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] rem_acc;
    logic [WIDTH-1:0] q_shift;
    logic [WIDTH-1:0] divisor_q;
    logic [WIDTH-1:0] dividend_q;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] q_step;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_r;

    assign shifted  = {rem_acc, q_shift[WIDTH-1]};
    assign trial    = shifted - {1'b0, divisor_q};
    assign rem_step = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign q_step   = {q_shift[WIDTH-2:0], ~trial[WIDTH]};

`ifdef DIVIDER_SIGNED_EN
    logic neg_q;
    logic neg_r;

    assign a_mag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
    assign b_mag = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
    // Most-negative / -1 yields magnitude 2^(WIDTH-1) with no negation, which is most-negative again.
    assign res_q = neg_q ? (~q_step + 1'b1) : q_step;
    assign res_r = neg_r ? (~rem_step + 1'b1) : rem_step;

    always_ff @(posedge clk) begin
        if (!reset) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if ((state == IDLE || state == DONE) && start) begin
            neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r <= dividend[WIDTH-1];
        end
    end
`else
    assign a_mag = dividend;
    assign b_mag = divisor;
    assign res_q = q_step;
    assign res_r = rem_step;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            rem_acc     <= '0;
            q_shift     <= '0;
            divisor_q   <= '0;
            dividend_q  <= '0;
            count       <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        quotient    <= '0;
                        remainder   <= '0;
                        done        <= 1'b0;
                        div_by_zero <= 1'b0;
                        rem_acc     <= '0;
                        q_shift     <= a_mag;
                        divisor_q   <= b_mag;
                        dividend_q  <= dividend;
                        count       <= CW'(WIDTH);
                        if (divisor == '0) begin
                            state <= ZDIV;
                            busy  <= 1'b0;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    rem_acc <= rem_step;
                    q_shift <= q_step;
                    count   <= count - 1'b1;
                    if (count == CW'(1)) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= res_q;
                        remainder <= res_r;
                    end
                end
                ZDIV: begin
                    state       <= DONE;
                    done        <= 1'b1;
                    div_by_zero <= 1'b1;
                    quotient    <= '1;
                    remainder   <= dividend_q;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sequential_divider.sv
// tb/tb_sequential_divider.sv - directed self-checking bench for sequential_divider
module tb_sequential_divider;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    int checks = 0;
    int errors = 0;

    sequential_divider #(.WIDTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_done(output int lat, output int bcnt, input int start_lat);
        lat  = start_lat;
        bcnt = 0;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input int eq, input int er, input int edz, input int elat, input int ebusy);
        int lat;
        int bcnt;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_q_cleared"}, {24'd0, quotient}, 32'd0);
        wait_done(lat, bcnt, 0);
        check({tag, "_latency"}, lat, elat);
        check({tag, "_busy_cycles"}, bcnt, ebusy);
        check({tag, "_quotient"}, {24'd0, quotient}, eq);
        check({tag, "_remainder"}, {24'd0, remainder}, er);
        check({tag, "_div_by_zero"}, {31'd0, div_by_zero}, edz);
    endtask

    initial begin
        int lat;
        int bcnt;
        reset    = 1'b0;
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_quotient", {24'd0, quotient}, 0);
        check("rst_remainder", {24'd0, remainder}, 0);
        check("rst_dbz", {31'd0, div_by_zero}, 0);
        reset = 1'b1;

        // Reset asserted in the middle of a division aborts it
        @(negedge clk);
        dividend = 8'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("midrun_busy_before", {31'd0, busy}, 1);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("midrun_rst_busy", {31'd0, busy}, 0);
        check("midrun_rst_done", {31'd0, done}, 0);
        check("midrun_rst_quotient", {24'd0, quotient}, 0);
        check("midrun_rst_remainder", {24'd0, remainder}, 0);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        check("midrun_idle_done", {31'd0, done}, 0);
        check("midrun_idle_busy", {31'd0, busy}, 0);

        do_div("d100_7", 8'd100, 8'd7, 14, 2, 0, 8, 8);
        do_div("d255_1", 8'd255, 8'd1, 255, 0, 0, 8, 8);
        do_div("d0_5", 8'd0, 8'd5, 0, 0, 0, 8, 8);
`ifndef DIVIDER_SIGNED_EN
        do_div("d5_255", 8'd5, 8'd255, 0, 5, 0, 8, 8);
`endif
        do_div("d37_0", 8'd37, 8'd0, 255, 37, 1, 1, 0);
        do_div("d13_13", 8'd13, 8'd13, 1, 0, 0, 8, 8);
        do_div("d127_10", 8'd127, 8'd10, 12, 7, 0, 8, 8);

        // Start pulsed during RUN with different operands must be ignored
        @(negedge clk);
        dividend = 8'd120;
        divisor  = 8'd9;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        dividend = 8'd50;
        divisor  = 8'd5;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 8'd0;
        wait_done(lat, bcnt, 3);
        check("ignore_latency", lat, 8);
        check("ignore_quotient", {24'd0, quotient}, 13);
        check("ignore_remainder", {24'd0, remainder}, 3);

        // Start held high restarts on reaching DONE
        @(negedge clk);
        dividend = 8'd9;
        divisor  = 8'd3;
        start    = 1'b1;
        @(negedge clk);
        wait_done(lat, bcnt, 0);
        check("b2b_first_latency", lat, 8);
        check("b2b_first_quotient", {24'd0, quotient}, 3);
        check("b2b_first_remainder", {24'd0, remainder}, 0);
        @(negedge clk);
        start = 1'b0;
        check("b2b_restart_done", {31'd0, done}, 0);
        check("b2b_restart_busy", {31'd0, busy}, 1);
        check("b2b_restart_quotient", {24'd0, quotient}, 0);
        wait_done(lat, bcnt, 0);
        check("b2b_second_latency", lat, 8);
        check("b2b_second_quotient", {24'd0, quotient}, 3);

        @(negedge clk);
        check("done_hold", {31'd0, done}, 1);
        check("done_hold_quotient", {24'd0, quotient}, 3);

`ifdef DIVIDER_SIGNED_EN
        do_div("s_m7_2", 8'hF9, 8'h02, 8'hFD, 8'hFF, 0, 8, 8);
        do_div("s_7_m2", 8'h07, 8'hFE, 8'hFD, 8'h01, 0, 8, 8);
        do_div("s_m128_m1", 8'h80, 8'hFF, 8'h80, 8'h00, 0, 8, 8);
        do_div("s_m5_0", 8'hFB, 8'h00, 8'hFF, 8'hFB, 1, 1, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
